sm_hex_display_scan: RTL and testbench

//  Parametrised, time-multiplexed hex display controller for N-digit 7-segment banks.

---
 rtl/sm_display_pkg.sv | 37 +++
 rtl/sm_hex_display.sv | 10 +
 rtl/sm_hex_display_scan.sv | 171 +++++++++++++++++
 tb/tb_sm_hex_display_scan.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_display_pkg.sv
// Shared definitions for the hex display controller: the hex-to-7-segment
// table, the blank segment pattern and the pin polarity helper.
package sm_display_pkg;

    // Blank segment pattern, active-high {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Converts an active-high {dp,seg} pin group to board polarity
    function automatic logic [7:0] apply_polarity(input logic active_low, input logic [7:0] pins);
        return active_low ? ~pins : pins;
    endfunction

endpackage

// File: rtl/sm_hex_display.sv
// Combinational single-nibble hex to 7-segment decoder (active-high output).
module sm_hex_display (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import sm_display_pkg::*;

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/sm_hex_display_scan.sv
// Time-multiplexed N-digit 7-segment controller with double-buffered,
// tear-free value updates, leading-zero blanking, per-digit blink and
// per-digit decimal point.
module sm_hex_display_scan #(
    parameter int DIGITS        = 8,
    parameter int SCAN_DIV      = 50000,
    parameter int BLINK_FRAMES  = 64,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  busy,
    output logic                  load_done,
    output logic                  frame_tick,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);
    import sm_display_pkg::*;

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES) + 1;

    localparam logic [PW-1:0]     PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic              POL_LOW    = (ACTIVE_LOW != 0);
    localparam logic [7:0]        PINS_OFF   = apply_polarity(POL_LOW, {1'b0, SEG_OFF});
    localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{POL_LOW}};
    localparam logic [DIGITS-1:0] AN_ONE     = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [PW-1:0]         prescaler;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  frame_end;
    logic [4*DIGITS-1:0]   staging;
    logic [4*DIGITS-1:0]   shadow;
    logic                  pending;
    logic [BW-1:0]         blink_cnt;
    logic                  phase;

    logic [3:0]            nib_p0;
    logic                  zero_run_p0;
    logic                  blank_p0;
    logic                  blink_sel_p0;
    logic                  dp_sel_p0;
    logic                  dark_p0;
    logic [6:0]            seg_raw_p0;
    logic [6:0]            seg_on_p0;
    logic                  dp_on_p0;
    logic [7:0]            pins_p0;

    logic [6:0]            seg_p1;
    logic                  dp_p1;
    logic [DIGITS-1:0]     an_p1;

    assign tick      = (prescaler == PRE_LAST);
    assign frame_end = tick && (idx == IDX_LAST);
    assign busy      = pending;

    // Prescaler and digit index; frame_tick marks the cycle after the last digit slot ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (tick) begin
                prescaler <= '0;
                idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // Load handshake: staging collects writes, shadow only changes on a frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging   <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load && frame_end) begin
                // A write landing exactly on the boundary goes straight to the display
                staging   <= data;
                shadow    <= data;
                pending   <= 1'b0;
                load_done <= 1'b1;
            end else if (frame_end && pending) begin
                shadow    <= staging;
                pending   <= 1'b0;
                load_done <= 1'b1;
            end else if (load) begin
                staging <= data;
                pending <= 1'b1;
            end
        end
    end

    // Blink phase toggles every BLINK_FRAMES completed frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Stage p0: select the current digit's nibble, masks and leading-zero state
    always_comb begin
        nib_p0       = 4'h0;
        zero_run_p0  = 1'b1;
        blank_p0     = 1'b0;
        blink_sel_p0 = 1'b0;
        dp_sel_p0    = 1'b0;
        // zero_run_p0 tracks "every nibble from the top down to i is zero"
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_p0 = zero_run_p0 && (shadow[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                nib_p0       = shadow[4*i +: 4];
                blank_p0     = (BLANK_LEADING != 0) && (i != 0) && zero_run_p0;
                blink_sel_p0 = blink_mask[i];
                dp_sel_p0    = dp_mask[i];
            end
        end
    end

    sm_hex_display u_dec (
        .nibble (nib_p0),
        .seg    (seg_raw_p0)
    );

    assign dark_p0   = phase && blink_sel_p0;
    assign seg_on_p0 = (blank_p0 || dark_p0) ? SEG_OFF : seg_raw_p0;
    assign dp_on_p0  = dp_sel_p0 && !dark_p0;
    assign pins_p0   = apply_polarity(POL_LOW, {dp_on_p0, seg_on_p0});

    // Stage p1: registered pin drivers, one cycle behind the digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_p1 <= PINS_OFF[6:0];
            dp_p1  <= PINS_OFF[7];
            an_p1  <= AN_OFF;
        end else begin
            seg_p1 <= pins_p0[6:0];
            dp_p1  <= pins_p0[7];
            an_p1  <= (AN_ONE << idx) ^ AN_OFF;
        end
    end

    assign seg = seg_p1;
    assign dp  = dp_p1;
    assign an  = an_p1;

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Self-checking bench for sm_hex_display_scan with a 4-digit, fast-scan configuration.
module tb_sm_hex_display_scan;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic        load;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic        busy;
    logic        load_done;
    logic        frame_tick;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   ld_pulses    = 0;
    exp_t exp_q[$];

    sm_hex_display_scan #(
        .DIGITS        (4),
        .SCAN_DIV      (4),
        .BLINK_FRAMES  (2),
        .ACTIVE_LOW    (1),
        .BLANK_LEADING (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .load       (load),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .busy       (busy),
        .load_done  (load_done),
        .frame_tick (frame_tick),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Active-high reference glyphs {g,f,e,d,c,b,a}
    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    // Queue the four active-low digit images expected for one frame
    task automatic push_frame(input logic [15:0] value, input logic [3:0] dpm,
                              input logic [3:0] bm, input logic blink_phase);
        for (int d = 0; d < 4; d++) begin
            exp_t        e;
            logic [15:0] upper;
            logic        blank;
            logic        dark;
            upper = value >> (4 * d);
            blank = (d != 0) && (upper == 16'h0000);
            dark  = blink_phase && bm[d];
            e.an  = ~(4'b0001 << d);
            e.seg = (blank || dark) ? 7'h7F : ~ref_glyph(upper[3:0]);
            e.dp  = ~(dpm[d] && !dark);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_frame_tick(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_frame_tick: got no pulse in 64 cycles, required a pulse", tag);
        end
    endtask

    // Observe one full frame (16 cycles) starting right after a frame_tick,
    // optionally issuing loads after given sample numbers.
    task automatic scan_frame(input logic [15:0] da, input int at_a,
                              input logic [15:0] db, input int at_b);
        exp_t e;
        logic any_load;
        logic exp_busy;
        logic exp_ld;
        logic exp_ft;
        e        = '0;
        any_load = (at_a >= 0) || (at_b >= 0);
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            if (s % 4 == 0) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_empty: got empty queue at sample %0d, required an entry", s);
                end else begin
                    e = exp_q.pop_front();
                end
            end
            tests_run++;
            if (an !== e.an) begin
                tests_failed++;
                $display("FAIL scan_an s=%0d: got %b, required %b", s, an, e.an);
            end
            tests_run++;
            if (seg !== e.seg) begin
                tests_failed++;
                $display("FAIL scan_seg s=%0d an=%b: got %b, required %b", s, e.an, seg, e.seg);
            end
            tests_run++;
            if (dp !== e.dp) begin
                tests_failed++;
                $display("FAIL scan_dp s=%0d an=%b: got %b, required %b", s, e.an, dp, e.dp);
            end
            exp_busy = ((at_a >= 0) && (s > at_a) && (s < 15)) ||
                       ((at_b >= 0) && (s > at_b) && (s < 15));
            exp_ld   = any_load && (s == 15);
            exp_ft   = (s == 15);
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL scan_busy s=%0d: got %b, required %b", s, busy, exp_busy);
            end
            tests_run++;
            if (load_done !== exp_ld) begin
                tests_failed++;
                $display("FAIL scan_load_done s=%0d: got %b, required %b", s, load_done, exp_ld);
            end
            tests_run++;
            if (frame_tick !== exp_ft) begin
                tests_failed++;
                $display("FAIL scan_frame_tick s=%0d: got %b, required %b", s, frame_tick, exp_ft);
            end
            if (load_done === 1'b1) ld_pulses++;
            if (s == at_a) begin
                data = da;
                load = 1'b1;
            end else if (s == at_b) begin
                data = db;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (an !== 4'b1111) begin tests_failed++; $display("FAIL reset_an: got %b, required 1111", an); end
        tests_run++;
        if (seg !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg: got %h, required 7f", seg); end
        tests_run++;
        if (dp !== 1'b1) begin tests_failed++; $display("FAIL reset_dp: got %b, required 1", dp); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests_run++;
        if (load_done !== 1'b0) begin tests_failed++; $display("FAIL reset_load_done: got %b, required 0", load_done); end
        tests_run++;
        if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_tick: got %b, required 0", frame_tick); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (an !== 4'b1110) begin tests_failed++; $display("FAIL first_digit_an: got %b, required 1110", an); end
        tests_run++;
        if (seg !== 7'b1000000) begin tests_failed++; $display("FAIL first_digit_seg: got %b, required 1000000", seg); end
    endtask

    task automatic test_scan();
        ld_pulses = 0;
        wait_frame_tick("scan_sync");
        push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0);
        scan_frame(16'h1234, 3, 16'h0000, -1);
        push_frame(16'h1234, 4'b0000, 4'b0000, 1'b0);
        scan_frame(16'h0000, -1, 16'h0000, -1);
        @(negedge clk);
        tests_run++;
        if (an !== 4'b1110) begin tests_failed++; $display("FAIL scan_wrap_an: got %b, required 1110", an); end
        tests_run++;
        if (seg !== 7'b0011001) begin tests_failed++; $display("FAIL scan_wrap_seg: got %b, required 0011001", seg); end
        tests_run++;
        if (ld_pulses != 1) begin tests_failed++; $display("FAIL scan_load_done_count: got %0d, required 1", ld_pulses); end
    endtask

    task automatic test_tear_free();
        ld_pulses = 0;
        wait_frame_tick("tear_sync");
        push_frame(16'h1234, 4'b0000, 4'b0000, 1'b0);
        scan_frame(16'h1234, 2, 16'hABCD, 8);
        push_frame(16'hABCD, 4'b0000, 4'b0000, 1'b0);
        scan_frame(16'h0000, -1, 16'h0000, -1);
        tests_run++;
        if (ld_pulses != 1) begin tests_failed++; $display("FAIL tear_load_done_count: got %0d, required 1", ld_pulses); end
    endtask

    task automatic test_blanking();
        dp_mask = 4'b0100;
        push_frame(16'hABCD, 4'b0100, 4'b0000, 1'b0);
        scan_frame(16'h0050, 2, 16'h0000, -1);
        push_frame(16'h0050, 4'b0100, 4'b0000, 1'b0);
        scan_frame(16'h0000, 4, 16'h0000, -1);
        push_frame(16'h0000, 4'b0100, 4'b0000, 1'b0);
        scan_frame(16'h0000, -1, 16'h0000, -1);
        dp_mask = 4'b0000;
    endtask

    task automatic test_midop_reset();
        wait_frame_tick("midrst_sync");
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 8) begin
                data = 16'h5A5A;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_pending: got %b, required 1", busy); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (an !== 4'b1111) begin tests_failed++; $display("FAIL midrst_an: got %b, required 1111", an); end
        tests_run++;
        if (seg !== 7'h7F) begin tests_failed++; $display("FAIL midrst_seg: got %h, required 7f", seg); end
        tests_run++;
        if (dp !== 1'b1) begin tests_failed++; $display("FAIL midrst_dp: got %b, required 1", dp); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (an !== 4'b1110) begin tests_failed++; $display("FAIL midrst_restart_an: got %b, required 1110", an); end
        tests_run++;
        if (seg !== 7'b1000000) begin tests_failed++; $display("FAIL midrst_restart_seg: got %b, required 1000000", seg); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_restart_busy: got %b, required 0", busy); end
    endtask

    // Starts right after a reset release, so the blink phase begins at 0
    task automatic test_blink();
        blink_mask = 4'b0001;
        @(negedge clk);
        data = 16'h1111;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame_tick("blink_sync");
        push_frame(16'h1111, 4'b0000, 4'b0001, 1'b0);
        scan_frame(16'h0000, -1, 16'h0000, -1);
        push_frame(16'h1111, 4'b0000, 4'b0001, 1'b1);
        scan_frame(16'h0000, -1, 16'h0000, -1);
        push_frame(16'h1111, 4'b0000, 4'b0001, 1'b1);
        scan_frame(16'h0000, -1, 16'h0000, -1);
        push_frame(16'h1111, 4'b0000, 4'b0001, 1'b0);
        scan_frame(16'h0000, -1, 16'h0000, -1);
        push_frame(16'h1111, 4'b0000, 4'b0001, 1'b0);
        scan_frame(16'h0000, -1, 16'h0000, -1);
        blink_mask = 4'b0000;
    endtask

    initial begin
        rst        = 1'b0;
        data       = 16'h0000;
        load       = 1'b0;
        blink_mask = 4'b0000;
        dp_mask    = 4'b0000;
        test_reset();
        test_scan();
        test_tear_free();
        test_blanking();
        test_midop_reset();
        test_blink();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
